// File: rtl/baud_pkg.sv
// rtl/baud_pkg.sv - rate codes and divisor helpers shared by the baud tick generator
//
// Purpose:
//   Names the 4-bit rate codes driven by the control registers. Provides constant
//   functions that turn a code into a baud rate, and a baud rate into a rounded
//   clocks-per-oversample-tick divisor.
// Contents:
//   BAUD_300 .. BAUD_921600  table rate codes 0..11
//   BAUD_CUSTOM              code 15, divisor taken from software
//   baud_rate(code)          baud for a table code (12..14 alias 300)
//   baud_div(clk, baud, os)  round(clk / (baud * os))
package baud_pkg;

  localparam logic [3:0] BAUD_300    = 4'd0;
  localparam logic [3:0] BAUD_1200   = 4'd1;
  localparam logic [3:0] BAUD_2400   = 4'd2;
  localparam logic [3:0] BAUD_4800   = 4'd3;
  localparam logic [3:0] BAUD_9600   = 4'd4;
  localparam logic [3:0] BAUD_19200  = 4'd5;
  localparam logic [3:0] BAUD_38400  = 4'd6;
  localparam logic [3:0] BAUD_57600  = 4'd7;
  localparam logic [3:0] BAUD_115200 = 4'd8;
  localparam logic [3:0] BAUD_230400 = 4'd9;
  localparam logic [3:0] BAUD_460800 = 4'd10;
  localparam logic [3:0] BAUD_921600 = 4'd11;
  localparam logic [3:0] BAUD_CUSTOM = 4'd15;

  function automatic int unsigned baud_rate(input logic [3:0] code);
    case (code)
      BAUD_300:    return 300;
      BAUD_1200:   return 1200;
      BAUD_2400:   return 2400;
      BAUD_4800:   return 4800;
      BAUD_9600:   return 9600;
      BAUD_19200:  return 19200;
      BAUD_38400:  return 38400;
      BAUD_57600:  return 57600;
      BAUD_115200: return 115200;
      BAUD_230400: return 230400;
      BAUD_460800: return 460800;
      BAUD_921600: return 921600;
      default:     return 300;
    endcase
  endfunction

  // Rounded to nearest: add half the denominator before dividing. 64-bit
  // intermediates keep baud*os and the sum clear of 32-bit overflow.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud,
                                           input int unsigned os);
    longint unsigned den;
    longint unsigned num;
    den = longint'(baud) * longint'(os);
    num = longint'(clk_freq) + den / 2;
    return int'(num / den);
  endfunction

endpackage

// File: rtl/baud_div_lut.sv
// rtl/baud_div_lut.sv - rate code to divisor lookup with custom-divisor mux
//
// Purpose:
//   Combinational table of elaboration-time divisors, one per table rate code.
//   Code 15 selects the software divisor, clamped so 0 and 1 both mean "every clock".
// Ports:
//   baud_i    [3:0]        rate code
//   div_in_i  [DIV_W-1:0]  software divisor for BAUD_CUSTOM
//   div_o     [DIV_W-1:0]  divisor selected for this cycle
module baud_div_lut
  import baud_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 20
) (
  input  logic [3:0]       baud_i,
  input  logic [DIV_W-1:0] div_in_i,
  output logic [DIV_W-1:0] div_o
);

  // Every table entry is a constant, so no divider is ever built in hardware.
  localparam logic [DIV_W-1:0] DIV_300    = DIV_W'(baud_div(CLK_FREQ, baud_rate(BAUD_300), OVERSAMPLE));
  localparam logic [DIV_W-1:0] DIV_1200   = DIV_W'(baud_div(CLK_FREQ, baud_rate(BAUD_1200), OVERSAMPLE));
  localparam logic [DIV_W-1:0] DIV_2400   = DIV_W'(baud_div(CLK_FREQ, baud_rate(BAUD_2400), OVERSAMPLE));
  localparam logic [DIV_W-1:0] DIV_4800   = DIV_W'(baud_div(CLK_FREQ, baud_rate(BAUD_4800), OVERSAMPLE));
  localparam logic [DIV_W-1:0] DIV_9600   = DIV_W'(baud_div(CLK_FREQ, baud_rate(BAUD_9600), OVERSAMPLE));
  localparam logic [DIV_W-1:0] DIV_19200  = DIV_W'(baud_div(CLK_FREQ, baud_rate(BAUD_19200), OVERSAMPLE));
  localparam logic [DIV_W-1:0] DIV_38400  = DIV_W'(baud_div(CLK_FREQ, baud_rate(BAUD_38400), OVERSAMPLE));
  localparam logic [DIV_W-1:0] DIV_57600  = DIV_W'(baud_div(CLK_FREQ, baud_rate(BAUD_57600), OVERSAMPLE));
  localparam logic [DIV_W-1:0] DIV_115200 = DIV_W'(baud_div(CLK_FREQ, baud_rate(BAUD_115200), OVERSAMPLE));
  localparam logic [DIV_W-1:0] DIV_230400 = DIV_W'(baud_div(CLK_FREQ, baud_rate(BAUD_230400), OVERSAMPLE));
  localparam logic [DIV_W-1:0] DIV_460800 = DIV_W'(baud_div(CLK_FREQ, baud_rate(BAUD_460800), OVERSAMPLE));
  localparam logic [DIV_W-1:0] DIV_921600 = DIV_W'(baud_div(CLK_FREQ, baud_rate(BAUD_921600), OVERSAMPLE));

  logic [DIV_W-1:0] div_custom;

  // A divisor of 0 would never wrap the counter; treat it like 1.
  assign div_custom = (div_in_i > DIV_W'(1)) ? div_in_i : DIV_W'(1);

  always_comb begin
    div_o = DIV_300;
    case (baud_i)
      BAUD_300:    div_o = DIV_300;
      BAUD_1200:   div_o = DIV_1200;
      BAUD_2400:   div_o = DIV_2400;
      BAUD_4800:   div_o = DIV_4800;
      BAUD_9600:   div_o = DIV_9600;
      BAUD_19200:  div_o = DIV_19200;
      BAUD_38400:  div_o = DIV_38400;
      BAUD_57600:  div_o = DIV_57600;
      BAUD_115200: div_o = DIV_115200;
      BAUD_230400: div_o = DIV_230400;
      BAUD_460800: div_o = DIV_460800;
      BAUD_921600: div_o = DIV_921600;
      BAUD_CUSTOM: div_o = div_custom;
      default:     div_o = DIV_300;
    endcase
  end

endmodule

// File: rtl/baud_tick_gen.sv
// rtl/baud_tick_gen.sv - oversample and bit tick generator for the UART datapath
//
// Purpose:
//   Divides the system clock by the selected divisor to give a one-cycle TICK_OS,
//   and counts OVERSAMPLE of those to give a coincident one-cycle TICK_BIT.
//   A divisor change restarts both counters cleanly; RESYNC restarts at mid-bit.
// Ports:
//   CLK       system clock, rising edge
//   RESET_N   synchronous active-low reset
//   ENABLE    1 = count, 0 = counters cleared and ticks suppressed
//   BAUD      [3:0] rate code (15 = custom)
//   DIV_IN    [DIV_W-1:0] custom divisor
//   RESYNC    one-cycle realign pulse from RX start-bit detect
//   TICK_OS   oversample tick
//   TICK_BIT  bit tick
//   DIV_OUT   [DIV_W-1:0] divisor in effect
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DIV_W      = 20
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             ENABLE,
  input  logic [3:0]       BAUD,
  input  logic [DIV_W-1:0] DIV_IN,
  input  logic             RESYNC,
  output logic             TICK_OS,
  output logic             TICK_BIT,
  output logic [DIV_W-1:0] DIV_OUT
);

  localparam int unsigned      OS_W      = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OS_W-1:0]  OS_LAST   = OS_W'(OVERSAMPLE - 1);
  // Starting half way through the bit puts the next TICK_BIT at mid-bit.
  localparam logic [OS_W-1:0]  OS_MID    = OS_W'(OVERSAMPLE / 2);
  localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(baud_div(CLK_FREQ, baud_rate(BAUD_300), OVERSAMPLE));

  logic [DIV_W-1:0] div_next;
  logic [DIV_W-1:0] div_q,      div_d;
  logic [DIV_W-1:0] cnt_q,      cnt_d;
  logic [OS_W-1:0]  os_cnt_q,   os_cnt_d;
  logic             tick_os_q,  tick_os_d;
  logic             tick_bit_q, tick_bit_d;
  logic             rate_change;
  logic             cnt_wrap;

  baud_div_lut #(
    .CLK_FREQ   (CLK_FREQ),
    .OVERSAMPLE (OVERSAMPLE),
    .DIV_W      (DIV_W)
  ) u_lut (
    .baud_i   (BAUD),
    .div_in_i (DIV_IN),
    .div_o    (div_next)
  );

  assign rate_change = (div_next != div_q);
  assign cnt_wrap    = (cnt_q == div_q - DIV_W'(1));

  always_comb begin
    // div_q follows the selected divisor on every cycle, even while disabled,
    // so DIV_OUT always reports what will be used once counting resumes.
    div_d      = div_next;
    cnt_d      = cnt_q;
    os_cnt_d   = os_cnt_q;
    tick_os_d  = 1'b0;
    tick_bit_d = 1'b0;
    if (!ENABLE) begin
      cnt_d    = '0;
      os_cnt_d = '0;
    end else if (rate_change || RESYNC) begin
      // Restart the period on the new divisor; suppressing the tick here is
      // what prevents a short or doubled tick across the change.
      cnt_d    = '0;
      os_cnt_d = RESYNC ? OS_MID : '0;
    end else if (cnt_wrap) begin
      cnt_d     = '0;
      tick_os_d = 1'b1;
      if (os_cnt_q == OS_LAST) begin
        os_cnt_d   = '0;
        tick_bit_d = 1'b1;
      end else begin
        os_cnt_d = os_cnt_q + OS_W'(1);
      end
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      div_q      <= DIV_RESET;
      cnt_q      <= '0;
      os_cnt_q   <= '0;
      tick_os_q  <= 1'b0;
      tick_bit_q <= 1'b0;
    end else begin
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      os_cnt_q   <= os_cnt_d;
      tick_os_q  <= tick_os_d;
      tick_bit_q <= tick_bit_d;
    end
  end

  assign TICK_OS  = tick_os_q;
  assign TICK_BIT = tick_bit_q;
  assign DIV_OUT  = div_q;

endmodule

// File: tb/tb_baud_tick_gen.sv
// tb/tb_baud_tick_gen.sv - self-checking bench for baud_tick_gen
module tb_baud_tick_gen;

  localparam int CLK_FREQ = 100_000_000;
  localparam int OS       = 16;
  localparam int DIV_W    = 20;

  logic             CLK = 1'b0;
  logic             RESET_N;
  logic             ENABLE;
  logic [3:0]       BAUD;
  logic [DIV_W-1:0] DIV_IN;
  logic             RESYNC;
  logic             TICK_OS;
  logic             TICK_BIT;
  logic [DIV_W-1:0] DIV_OUT;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  baud_tick_gen #(
    .CLK_FREQ   (CLK_FREQ),
    .OVERSAMPLE (OS),
    .DIV_W      (DIV_W)
  ) dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .ENABLE   (ENABLE),
    .BAUD     (BAUD),
    .DIV_IN   (DIV_IN),
    .RESYNC   (RESYNC),
    .TICK_OS  (TICK_OS),
    .TICK_BIT (TICK_BIT),
    .DIV_OUT  (DIV_OUT)
  );

  // Reference model: the divisor from the rate rules, and ticks derived from
  // the edge count since the last restart ("anchor") by plain division.
  function automatic int model_div(input logic [3:0] code, input logic [DIV_W-1:0] din);
    longint b;
    if (code == 4'd15) return (din <= 1) ? 1 : int'(din);
    case (code)
      4'd0: b = 300;     4'd1: b = 1200;    4'd2: b = 2400;    4'd3: b = 4800;
      4'd4: b = 9600;    4'd5: b = 19200;   4'd6: b = 38400;   4'd7: b = 57600;
      4'd8: b = 115200;  4'd9: b = 230400;  4'd10: b = 460800; 4'd11: b = 921600;
      default: b = 300;
    endcase
    return int'((longint'(CLK_FREQ) + (b * OS) / 2) / (b * OS));
  endfunction

  int   n_edge = 0;
  int   anchor = 0;
  int   os0    = 0;
  int   md     = 20833;
  int   dn;
  int   k;
  logic m_os   = 1'b0;
  logic m_bit  = 1'b0;

  always @(posedge CLK) begin
    n_edge = n_edge + 1;
    dn = model_div(BAUD, DIV_IN);
    if (!RESET_N) begin
      md = model_div(4'd0, '0); anchor = n_edge; os0 = 0; m_os = 1'b0; m_bit = 1'b0;
    end else if (!ENABLE) begin
      md = dn; anchor = n_edge; os0 = 0; m_os = 1'b0; m_bit = 1'b0;
    end else if (dn != md || RESYNC) begin
      md = dn; anchor = n_edge; os0 = RESYNC ? OS / 2 : 0; m_os = 1'b0; m_bit = 1'b0;
    end else begin
      k = n_edge - anchor;
      m_os  = (k % md) == 0;
      m_bit = m_os && (((os0 + k / md) % OS) == 0);
    end
  end

  task automatic test_reset;
    RESET_N = 1'b0; ENABLE = 1'b1; BAUD = 4'd8; DIV_IN = '0; RESYNC = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (TICK_OS !== 1'b0 || TICK_BIT !== 1'b0) begin
      failures++;
      $display("FAIL reset_ticks tick_os=%b tick_bit=%b expected 0 0", TICK_OS, TICK_BIT);
    end
    checks++;
    if (DIV_OUT !== 20'd20833) begin
      failures++;
      $display("FAIL reset_div got=%0d expected=20833", DIV_OUT);
    end
  endtask

  task automatic test_table_rate;
    int last_os, last_bit, n_os, n_bit;
    last_os = 0; last_bit = 0; n_os = 0; n_bit = 0;
    RESET_N = 1'b1; RESYNC = 1'b0;
    for (int c = 1; c <= 1800; c++) begin
      @(negedge CLK);
      checks++;
      if (TICK_OS !== m_os || TICK_BIT !== m_bit || DIV_OUT !== DIV_W'(md)) begin
        failures++;
        $display("FAIL model_table c=%0d os=%b/%b bit=%b/%b div=%0d/%0d", c, TICK_OS, m_os, TICK_BIT, m_bit, DIV_OUT, md);
      end
      if (TICK_OS === 1'b1) begin
        if (last_os > 0) begin
          checks++;
          if (c - last_os != 54) begin
            failures++;
            $display("FAIL os_period_54 got=%0d expected=54", c - last_os);
          end
        end
        last_os = c; n_os++;
      end
      if (TICK_BIT === 1'b1) begin
        checks++;
        if (TICK_OS !== 1'b1) begin
          failures++;
          $display("FAIL bit_coincident tick_os=%b expected 1", TICK_OS);
        end
        if (last_bit > 0) begin
          checks++;
          if (c - last_bit != 864) begin
            failures++;
            $display("FAIL bit_period_864 got=%0d expected=864", c - last_bit);
          end
        end
        last_bit = c; n_bit++;
      end
    end
    checks++;
    if (DIV_OUT !== 20'd54) begin
      failures++;
      $display("FAIL div_115200 got=%0d expected=54", DIV_OUT);
    end
    checks++;
    if (n_os != 33 || n_bit != 2) begin
      failures++;
      $display("FAIL tick_counts os=%0d bit=%0d expected 33 2", n_os, n_bit);
    end
  endtask

  task automatic test_custom_div;
    int n;
    BAUD = 4'd15; DIV_IN = 20'd3; n = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge CLK);
      checks++;
      if (TICK_OS !== m_os || TICK_BIT !== m_bit || DIV_OUT !== DIV_W'(md)) begin
        failures++;
        $display("FAIL model_div3 c=%0d os=%b/%b bit=%b/%b div=%0d/%0d", c, TICK_OS, m_os, TICK_BIT, m_bit, DIV_OUT, md);
      end
      if (TICK_OS === 1'b1) n++;
    end
    checks++;
    if (n != 9 || DIV_OUT !== 20'd3) begin
      failures++;
      $display("FAIL custom_div3 ticks=%0d div=%0d expected 9 3", n, DIV_OUT);
    end
    DIV_IN = '0; n = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge CLK);
      if (c >= 2 && TICK_OS === 1'b1) n++;
    end
    checks++;
    if (n != 11 || DIV_OUT !== 20'd1) begin
      failures++;
      $display("FAIL custom_div0 ticks=%0d div=%0d expected 11 1", n, DIV_OUT);
    end
    for (int r = 0; r < 4; r++) begin
      DIV_IN = DIV_W'($urandom_range(1, 40));
      for (int c = 1; c <= 100; c++) begin
        @(negedge CLK);
        checks++;
        if (TICK_OS !== m_os || TICK_BIT !== m_bit || DIV_OUT !== DIV_W'(md)) begin
          failures++;
          $display("FAIL model_custom c=%0d os=%b/%b bit=%b/%b div=%0d/%0d", c, TICK_OS, m_os, TICK_BIT, m_bit, DIV_OUT, md);
        end
      end
    end
    BAUD = 4'd13;
    repeat (3) @(negedge CLK);
    checks++;
    if (DIV_OUT !== 20'd20833) begin
      failures++;
      $display("FAIL code13_div got=%0d expected=20833", DIV_OUT);
    end
  endtask

  task automatic test_rate_change;
    int first, second;
    first = 0; second = 0;
    BAUD = 4'd4;
    for (int c = 1; c <= 951; c++) begin
      @(negedge CLK);
      checks++;
      if (TICK_OS !== m_os || TICK_BIT !== m_bit || DIV_OUT !== DIV_W'(md)) begin
        failures++;
        $display("FAIL model_pre_change c=%0d os=%b/%b bit=%b/%b div=%0d/%0d", c, TICK_OS, m_os, TICK_BIT, m_bit, DIV_OUT, md);
      end
    end
    BAUD = 4'd0;
    for (int c = 1; c <= 41670 && second == 0; c++) begin
      @(negedge CLK);
      checks++;
      if (TICK_OS !== m_os || TICK_BIT !== m_bit || DIV_OUT !== DIV_W'(md)) begin
        failures++;
        $display("FAIL model_change c=%0d os=%b/%b bit=%b/%b div=%0d/%0d", c, TICK_OS, m_os, TICK_BIT, m_bit, DIV_OUT, md);
      end
      if (TICK_OS === 1'b1) begin
        if (first == 0) first = c; else second = c;
      end
    end
    checks++;
    if (first != 20834) begin
      failures++;
      $display("FAIL change_first_tick got=%0d expected=20834", first);
    end
    checks++;
    if (second - first != 20833) begin
      failures++;
      $display("FAIL change_period got=%0d expected=20833", second - first);
    end
  endtask

  task automatic test_resync;
    int first, second;
    first = 0; second = 0;
    BAUD = 4'd4;
    repeat (700) @(negedge CLK);
    RESYNC = 1'b1;
    for (int c = 1; c <= 15700 && second == 0; c++) begin
      @(negedge CLK);
      RESYNC = 1'b0;
      checks++;
      if (TICK_OS !== m_os || TICK_BIT !== m_bit || DIV_OUT !== DIV_W'(md)) begin
        failures++;
        $display("FAIL model_resync c=%0d os=%b/%b bit=%b/%b div=%0d/%0d", c, TICK_OS, m_os, TICK_BIT, m_bit, DIV_OUT, md);
      end
      if (TICK_BIT === 1'b1) begin
        if (first == 0) first = c; else second = c;
      end
    end
    checks++;
    if (first != 5209) begin
      failures++;
      $display("FAIL resync_first_bit got=%0d expected=5209", first);
    end
    checks++;
    if (second - first != 10416) begin
      failures++;
      $display("FAIL resync_bit_period got=%0d expected=10416", second - first);
    end
  endtask

  task automatic test_enable;
    int first_os, first_bit, n;
    first_os = 0; first_bit = 0; n = 0;
    repeat (300) @(negedge CLK);
    ENABLE = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge CLK);
      RESYNC = (c == 50);
      if (TICK_OS === 1'b1 || TICK_BIT === 1'b1) n++;
    end
    RESYNC = 1'b0;
    checks++;
    if (n != 0) begin
      failures++;
      $display("FAIL ticks_while_disabled got=%0d expected=0", n);
    end
    ENABLE = 1'b1;
    for (int c = 1; c <= 10420 && first_bit == 0; c++) begin
      @(negedge CLK);
      checks++;
      if (TICK_OS !== m_os || TICK_BIT !== m_bit || DIV_OUT !== DIV_W'(md)) begin
        failures++;
        $display("FAIL model_enable c=%0d os=%b/%b bit=%b/%b div=%0d/%0d", c, TICK_OS, m_os, TICK_BIT, m_bit, DIV_OUT, md);
      end
      if (TICK_OS === 1'b1 && first_os == 0) first_os = c;
      if (TICK_BIT === 1'b1) first_bit = c;
    end
    checks++;
    if (first_os != 651 || first_bit != 10416) begin
      failures++;
      $display("FAIL enable_first_ticks os=%0d bit=%0d expected 651 10416", first_os, first_bit);
    end
  endtask

  task automatic test_reset_mid;
    int first;
    first = 0;
    repeat (400) @(negedge CLK);
    RESET_N = 1'b0; RESYNC = 1'b1; BAUD = 4'd0;
    @(negedge CLK);
    checks++;
    if (TICK_OS !== 1'b0 || TICK_BIT !== 1'b0 || DIV_OUT !== 20'd20833) begin
      failures++;
      $display("FAIL reset_mid os=%b bit=%b div=%0d expected 0 0 20833", TICK_OS, TICK_BIT, DIV_OUT);
    end
    RESET_N = 1'b1; RESYNC = 1'b0; BAUD = 4'd4;
    for (int c = 2; c <= 700 && first == 0; c++) begin
      @(negedge CLK);
      checks++;
      if (TICK_OS !== m_os || TICK_BIT !== m_bit || DIV_OUT !== DIV_W'(md)) begin
        failures++;
        $display("FAIL model_reset_mid c=%0d os=%b/%b bit=%b/%b div=%0d/%0d", c, TICK_OS, m_os, TICK_BIT, m_bit, DIV_OUT, md);
      end
      if (TICK_OS === 1'b1) first = c;
    end
    checks++;
    if (first != 653) begin
      failures++;
      $display("FAIL reset_mid_first_tick got=%0d expected=653", first);
    end
  endtask

  task automatic test_random;
    logic [3:0] codes [5];
    codes[0] = 4'd8; codes[1] = 4'd9; codes[2] = 4'd10; codes[3] = 4'd11; codes[4] = 4'd15;
    for (int c = 1; c <= 4000; c++) begin
      @(negedge CLK);
      checks++;
      if (TICK_OS !== m_os || TICK_BIT !== m_bit || DIV_OUT !== DIV_W'(md)) begin
        failures++;
        $display("FAIL model_random c=%0d os=%b/%b bit=%b/%b div=%0d/%0d", c, TICK_OS, m_os, TICK_BIT, m_bit, DIV_OUT, md);
      end
      RESYNC  = ($urandom_range(0, 149) == 0);
      RESET_N = ($urandom_range(0, 1499) != 0);
      if ($urandom_range(0, 299) == 0) ENABLE = ~ENABLE;
      if ($urandom_range(0, 249) == 0) begin
        BAUD   = codes[$urandom_range(0, 4)];
        DIV_IN = DIV_W'($urandom_range(0, 60));
      end
    end
  endtask

  initial begin
    test_reset;
    test_table_rate;
    test_custom_div;
    test_rate_change;
    test_resync;
    test_enable;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
